operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Serial-to-parallel front end for the component under exploration (adder / mult / fma).
- Deserialises two WIDTH-bit operands from a single-bit input stream, MSB first, with framing and per-bit strobes.
- Presents the assembled pair to the downstream arithmetic stage with a valid/ready handshake.
- Replaces free-running shift registers, so operands are stable and framed while the downstream stage samples them.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  global enable; when low, all state frozen.
- start  input  1  frame start; aborts any frame in progress and begins a new one.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  qualifies bit_in this cycle.
- ina  output  WIDTH  assembled operand A.
- inb  output  WIDTH  assembled operand B.
- out_valid  output  1  ina/inb hold a complete pair.
- out_ready  input  1  downstream accepts the pair.
- busy  output  1  high in LOAD_A or LOAD_B.
- overrun  output  1  sticky: a bit arrived while a pair was pending.
- bit_count  output  CNT_W  bits captured in the current operand.

Behaviour:
- Reset (async assert, sync-release assumed upstream): state=IDLE; ina=0; inb=0; bit_count=0; out_valid=0; busy=0; overrun=0.
- States: IDLE, LOAD_A, LOAD_B, VALID. Every transition requires ena=1. With ena=0 no register changes and inputs are ignored.
- IDLE:
  - start -> LOAD_A, bit_count=0.
  - bit_valid without start is ignored.
- start in any state (ena=1):
  - Clears bit_count and goes to LOAD_A.
  - ina/inb keep their old contents until overwritten by shifting.
  - overrun is not cleared.
- Shifting: operand <= {operand[WIDTH-2:0], bit_in}. First bit received ends in the MSB. For WIDTH=1 the operand simply loads bit_in.
- start and bit_valid in the same cycle: that bit is captured as the first bit of the new A; bit_count becomes 1.
- LOAD_A:
  - Each bit_valid shifts ina and increments bit_count.
  - On the WIDTH-th bit: bit_count=0, go to LOAD_B.
- LOAD_B:
  - Same as LOAD_A, applied to inb.
  - On the WIDTH-th bit go to VALID.
  - out_valid is registered and rises the cycle after the edge sampling the last B bit. Latency from last bit edge to out_valid is 1 cycle.
- VALID:
  - out_valid=1; ina/inb stable.
  - out_ready=1 -> IDLE, out_valid low next cycle.
  - out_ready with start in the same cycle: the handshake completes and the block goes to LOAD_A (start wins the next state).
  - bit_valid without start -> overrun<=1; the bit is dropped and ina/inb are unchanged.
- out_valid, once high, stays high until accepted or until start is asserted.
- busy = (state==LOAD_A || state==LOAD_B), registered with state.
- overrun is cleared only by reset.
- Reset asserted mid-frame clears immediately (async); no partial pair is ever presented.

Decomposition:
- Shared package operand_loader_pkg:
  - State enum typedef (IDLE, LOAD_A, LOAD_B, VALID; 2-bit encoding).
  - Localparam MAX_WIDTH=32.
- No sub-module. The counter and the two shift registers are small and live in the single module. Target roughly 150 lines.

Test Plan (WIDTH=8, ena=1 unless stated):
1. Reset, start, 16 bits: 1010_0101 then 0011_1100 -> ina=0xA5, inb=0x3C; out_valid=1 exactly 1 cycle after the 16th bit edge; busy low in VALID; out_ready pulse -> out_valid=0 next cycle, state IDLE.
2. Backpressure: complete pair 0xFF/0x01, hold out_ready=0 for 5 cycles and send 2 extra bit_valid -> ina/inb stay 0xFF/0x01, overrun=1 sticky; overrun stays 1 after out_ready and the following pair.
3. Restart mid-frame: start, 5 bits of A, start again with bit_valid=1 in the same cycle, then 15 more bits -> bit_count=1 after the restart; final pair is built only from the 16 post-restart bits.
4. Enable gating: drop ena for 4 cycles in the middle of LOAD_B while toggling bit_valid -> bit_count and inb unchanged; resume yields the correct pair 0x5A/0xC3.
5. Async reset: assert rst_n=0 between clock edges during LOAD_B -> outputs zero immediately, without waiting for a clock edge; after release, idle until start.
6. Back-to-back: out_ready and start in the same cycle in VALID -> next state LOAD_A, out_valid=0; second pair 0x12/0x34 presented correctly.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// rtl/operand_loader_pkg.sv - shared types and limits for the operand loader
package operand_loader_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_A = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_VALID  = 2'd3
  } state_t;

endpackage

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - serial MSB-first deserialiser for an A/B operand pair
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   ena                 global enable; low freezes all state
//   start               begin a new frame (aborts any frame in progress)
//   bit_in, bit_valid   serial data and its strobe
//   ina, inb            assembled operands
//   out_valid/out_ready pair handshake to the arithmetic stage
//   busy                loading A or B
//   overrun             sticky: a bit arrived while a pair was pending
//   bit_count           bits captured into the current operand
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] ina,
  output logic [WIDTH-1:0] inb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_count
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("operand_loader: WIDTH out of range");
  end

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ina_q, ina_d;
  logic [WIDTH-1:0] inb_q, inb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  // State/count as seen by this cycle's bit: a start restarts the frame
  // first, so a bit arriving with start lands as the first bit of new A.
  state_t           eff_state;
  logic [CNT_W-1:0] eff_cnt;

  always_comb begin
    state_d   = state_q;
    ina_d     = ina_q;
    inb_d     = inb_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    eff_state = state_q;
    eff_cnt   = cnt_q;

    if (ena) begin
      if (start) begin
        eff_state = ST_LOAD_A;
        eff_cnt   = '0;
        state_d   = ST_LOAD_A;
        cnt_d     = '0;
      end

      case (eff_state)
        ST_LOAD_A: begin
          if (bit_valid) begin
            // Shift form also covers WIDTH=1, where it reduces to a load.
            ina_d = (ina_q << 1) | WIDTH'(bit_in);
            if (eff_cnt == LAST_BIT) begin
              cnt_d   = '0;
              state_d = ST_LOAD_B;
            end else begin
              cnt_d = eff_cnt + CNT_W'(1);
            end
          end
        end
        ST_LOAD_B: begin
          if (bit_valid) begin
            inb_d = (inb_q << 1) | WIDTH'(bit_in);
            if (eff_cnt == LAST_BIT) begin
              cnt_d   = '0;
              state_d = ST_VALID;
            end else begin
              cnt_d = eff_cnt + CNT_W'(1);
            end
          end
        end
        ST_VALID: begin
          // The pair is still pending while this bit arrives; it is dropped.
          if (bit_valid) begin
            overrun_d = 1'b1;
          end
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
        end
      endcase
    end

    out_valid_d = (state_d == ST_VALID);
    busy_d      = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ina_q       <= '0;
      inb_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ina_q       <= ina_d;
      inb_q       <= inb_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ina       = ina_q;
  assign inb       = inb_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - directed self-checking bench for operand_loader
module tb_operand_loader;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] bit_count;

  int n_cmp = 0;
  int n_bad = 0;

  operand_loader #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .ina       (ina),
    .inb       (inb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun),
    .bit_count (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bit_valid = 1'b1;
      bit_in    = v[i];
      step();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({ina, inb, bit_count, out_valid, busy, overrun} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h required 0", {ina, inb, bit_count, out_valid, busy, overrun});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1 || bit_count !== 4'd0) begin
      n_bad++;
      $display("FAIL basic_start: busy=%b cnt=%0d required busy=1 cnt=0", busy, bit_count);
    end
    send_bits(8'hA5, 8);
    n_cmp++;
    if (ina !== 8'hA5 || bit_count !== 4'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_a_done: ina=%h cnt=%0d busy=%b required A5 0 1", ina, bit_count, busy);
    end
    send_bits(8'h3C, 7);
    n_cmp++;
    if (out_valid !== 1'b0 || bit_count !== 4'd7) begin
      n_bad++;
      $display("FAIL basic_before_last: out_valid=%b cnt=%0d required 0 7", out_valid, bit_count);
    end
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    step();
    bit_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || ina !== 8'hA5 || inb !== 8'h3C || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pair: ov=%b ina=%h inb=%h busy=%b required 1 A5 3C 0", out_valid, ina, inb, busy);
    end
    accept();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_accept: out_valid=%b busy=%b required 0 0", out_valid, busy);
    end
    send_bits(8'hFF, 2);
    n_cmp++;
    if (bit_count !== 4'd0 || busy !== 1'b0 || ina !== 8'hA5) begin
      n_bad++;
      $display("FAIL idle_ignore: cnt=%0d busy=%b ina=%h required 0 0 A5", bit_count, busy, ina);
    end
  endtask

  task automatic test_backpressure();
    pulse_start();
    send_bits(8'hFF, 8);
    send_bits(8'h01, 8);
    for (int c = 0; c < 5; c++) begin
      bit_valid = (c == 1 || c == 3);
      bit_in    = 1'b0;
      step();
    end
    bit_valid = 1'b0;
    n_cmp++;
    if (ina !== 8'hFF || inb !== 8'h01 || out_valid !== 1'b1 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_hold: ina=%h inb=%h ov=%b overrun=%b required FF 01 1 1", ina, inb, out_valid, overrun);
    end
    accept();
    n_cmp++;
    if (overrun !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_after_accept: overrun=%b ov=%b required 1 0", overrun, out_valid);
    end
    pulse_start();
    send_bits(8'h0F, 8);
    send_bits(8'hF0, 8);
    n_cmp++;
    if (ina !== 8'h0F || inb !== 8'hF0 || out_valid !== 1'b1 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_next_pair: ina=%h inb=%h ov=%b overrun=%b required 0F F0 1 1", ina, inb, out_valid, overrun);
    end
    accept();
  endtask

  task automatic test_restart();
    logic [7:0] a;
    a = 8'h69;
    pulse_start();
    send_bits(8'hF8, 5);
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = a[7];
    step();
    start     = 1'b0;
    bit_valid = 1'b0;
    n_cmp++;
    if (bit_count !== 4'd1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_count: cnt=%0d busy=%b required 1 1", bit_count, busy);
    end
    send_bits(a << 1, 7);
    send_bits(8'h96, 8);
    n_cmp++;
    if (ina !== 8'h69 || inb !== 8'h96 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_pair: ina=%h inb=%h ov=%b required 69 96 1", ina, inb, out_valid);
    end
    accept();
  endtask

  task automatic test_enable();
    pulse_start();
    send_bits(8'h5A, 8);
    send_bits(8'hC3, 4);
    ena = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bit_valid = c[0];
      bit_in    = ~c[0];
      step();
    end
    bit_valid = 1'b0;
    n_cmp++;
    if (bit_count !== 4'd4 || inb !== 8'h6C || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ena_frozen: cnt=%0d inb=%h busy=%b required 4 6C 1", bit_count, inb, busy);
    end
    ena = 1'b1;
    send_bits(8'h30, 4);
    n_cmp++;
    if (ina !== 8'h5A || inb !== 8'hC3 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ena_resume: ina=%h inb=%h ov=%b required 5A C3 1", ina, inb, out_valid);
    end
    accept();
  endtask

  task automatic test_async_reset();
    pulse_start();
    send_bits(8'h11, 8);
    send_bits(8'hE0, 3);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ina, inb, bit_count, out_valid, busy, overrun} !== 23'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %h required 0", {ina, inb, bit_count, out_valid, busy, overrun});
    end
    #2;
    rst_n = 1'b1;
    step();
    send_bits(8'hFF, 3);
    n_cmp++;
    if (busy !== 1'b0 || bit_count !== 4'd0 || out_valid !== 1'b0 || ina !== 8'h00) begin
      n_bad++;
      $display("FAIL post_reset_idle: busy=%b cnt=%0d ov=%b ina=%h required 0 0 0 00", busy, bit_count, out_valid, ina);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    send_bits(8'hAB, 8);
    send_bits(8'hCD, 8);
    n_cmp++;
    if (ina !== 8'hAB || inb !== 8'hCD || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_first: ina=%h inb=%h ov=%b required AB CD 1", ina, inb, out_valid);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || bit_count !== 4'd0) begin
      n_bad++;
      $display("FAIL b2b_handoff: ov=%b busy=%b cnt=%0d required 0 1 0", out_valid, busy, bit_count);
    end
    send_bits(8'h12, 8);
    send_bits(8'h34, 8);
    n_cmp++;
    if (ina !== 8'h12 || inb !== 8'h34 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second: ina=%h inb=%h ov=%b overrun=%b required 12 34 1 0", ina, inb, out_valid, overrun);
    end
    accept();
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_restart();
    test_enable();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
